// File: rtl/id_exe_pipe_ctrl.sv
// ID/EX pipeline register with the EX->MEM->WB destination tracking chain.
// Optional bubble statistics counter enabled by defining STALL_STATS_EN.
module id_exe_pipe_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned ALUC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrn,
    input  logic              flush,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [REG_AW-1:0] d_rw,
    input  logic              d_reg_write,
    input  logic              d_memtoreg,
    input  logic              d_wmem,
    input  logic [ALUC_W-1:0] d_aluc,
    input  logic [DATA_W-1:0] d_qa,
    input  logic [DATA_W-1:0] d_qb,
    input  logic [DATA_W-1:0] d_imm,
    output logic [REG_AW-1:0] e_rs,
    output logic [REG_AW-1:0] e_rt,
    output logic [REG_AW-1:0] e_rw,
    output logic [REG_AW-1:0] m_rw,
    output logic [REG_AW-1:0] w_rw,
    output logic              e_reg_write,
    output logic              m_reg_write,
    output logic              w_reg_write,
    output logic              e_memtoreg,
    output logic              m_memtoreg,
    output logic              e_wmem,
    output logic [ALUC_W-1:0] e_aluc,
    output logic [DATA_W-1:0] e_qa,
    output logic [DATA_W-1:0] e_qb,
    output logic [DATA_W-1:0] e_imm,
    output logic              bubble,
    output logic [15:0]       stall_cnt
);

    logic insert_bubble;
    logic live_write;

    // Flush and load-use stall both replace the EXE slot with a bubble.
    assign insert_bubble = flush | ~wrn;
    // Dead writes and $0 writes must never expose a nonzero index downstream.
    assign live_write    = d_reg_write & (d_rw != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_rs        <= '0;
            e_rt        <= '0;
            e_rw        <= '0;
            m_rw        <= '0;
            w_rw        <= '0;
            e_reg_write <= 1'b0;
            m_reg_write <= 1'b0;
            w_reg_write <= 1'b0;
            e_memtoreg  <= 1'b0;
            m_memtoreg  <= 1'b0;
            e_wmem      <= 1'b0;
            e_aluc      <= '0;
            e_qa        <= '0;
            e_qb        <= '0;
            e_imm       <= '0;
            bubble      <= 1'b1;
        end else begin
            // Downstream stages always advance.
            w_rw        <= m_rw;
            w_reg_write <= m_reg_write;
            m_rw        <= e_rw;
            m_reg_write <= e_reg_write;
            m_memtoreg  <= e_memtoreg;
            if (insert_bubble) begin
                e_rs        <= '0;
                e_rt        <= '0;
                e_rw        <= '0;
                e_reg_write <= 1'b0;
                e_memtoreg  <= 1'b0;
                e_wmem      <= 1'b0;
                e_aluc      <= '0;
                e_qa        <= '0;
                e_qb        <= '0;
                e_imm       <= '0;
                bubble      <= 1'b1;
            end else begin
                e_rs        <= d_rs;
                e_rt        <= d_rt;
                e_rw        <= live_write ? d_rw : '0;
                e_reg_write <= live_write;
                e_memtoreg  <= d_memtoreg & live_write;
                e_wmem      <= d_wmem;
                e_aluc      <= d_aluc;
                e_qa        <= d_qa;
                e_qb        <= d_qb;
                e_imm       <= d_imm;
                bubble      <= 1'b0;
            end
        end
    end

`ifdef STALL_STATS_EN
    // Saturating count of load-use bubbles; flush-only bubbles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0;
        end else if (!wrn && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_id_exe_pipe_ctrl.sv
// Self-checking bench for id_exe_pipe_ctrl: directed steps then random traffic
// against a slot-based reference model of the EXE/MEM/WB stages.
module tb_id_exe_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, wrn, flush;
    logic [4:0]  d_rs, d_rt, d_rw;
    logic        d_reg_write, d_memtoreg, d_wmem;
    logic [3:0]  d_aluc;
    logic [31:0] d_qa, d_qb, d_imm;
    logic [4:0]  e_rs, e_rt, e_rw, m_rw, w_rw;
    logic        e_reg_write, m_reg_write, w_reg_write;
    logic        e_memtoreg, m_memtoreg, e_wmem;
    logic [3:0]  e_aluc;
    logic [31:0] e_qa, e_qb, e_imm;
    logic        bubble;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    id_exe_pipe_ctrl dut (
        .clk(clk), .rst(rst), .wrn(wrn), .flush(flush),
        .d_rs(d_rs), .d_rt(d_rt), .d_rw(d_rw),
        .d_reg_write(d_reg_write), .d_memtoreg(d_memtoreg), .d_wmem(d_wmem),
        .d_aluc(d_aluc), .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm),
        .e_rs(e_rs), .e_rt(e_rt), .e_rw(e_rw), .m_rw(m_rw), .w_rw(w_rw),
        .e_reg_write(e_reg_write), .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
        .e_memtoreg(e_memtoreg), .m_memtoreg(m_memtoreg), .e_wmem(e_wmem),
        .e_aluc(e_aluc), .e_qa(e_qa), .e_qb(e_qb), .e_imm(e_imm),
        .bubble(bubble), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // One instruction slot as seen by the pipeline.
    typedef struct packed {
        logic [4:0]  rs, rt, rw;
        logic        wr, ld, st;
        logic [3:0]  aluc;
        logic [31:0] qa, qb, imm;
        logic        bub;
    } slot_t;

    slot_t stg[3];          // 0 = EXE, 1 = MEM, 2 = WB
    int    model_cnt = 0;

    function automatic slot_t empty_slot();
        slot_t s = '0;
        s.bub = 1'b1;
        return s;
    endfunction

    // Reference: an instruction that writes nothing or writes $0 is "no destination".
    function automatic slot_t decode_slot();
        slot_t s = '0;
        bit    writes = (d_reg_write == 1'b1) && (d_rw != 5'd0);
        s.rs   = d_rs;
        s.rt   = d_rt;
        s.rw   = writes ? d_rw : 5'd0;
        s.wr   = writes;
        s.ld   = writes && d_memtoreg;
        s.st   = d_wmem;
        s.aluc = d_aluc;
        s.qa   = d_qa;
        s.qb   = d_qb;
        s.imm  = d_imm;
        s.bub  = 1'b0;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] exp_cnt;
`ifdef STALL_STATS_EN
        exp_cnt = 16'(model_cnt);
`else
        exp_cnt = 16'h0;
`endif
        check("e_rs", 32'(e_rs), 32'(stg[0].rs));
        check("e_rt", 32'(e_rt), 32'(stg[0].rt));
        check("e_rw", 32'(e_rw), 32'(stg[0].rw));
        check("e_reg_write", 32'(e_reg_write), 32'(stg[0].wr));
        check("e_memtoreg", 32'(e_memtoreg), 32'(stg[0].ld));
        check("e_wmem", 32'(e_wmem), 32'(stg[0].st));
        check("e_aluc", 32'(e_aluc), 32'(stg[0].aluc));
        check("e_qa", e_qa, stg[0].qa);
        check("e_qb", e_qb, stg[0].qb);
        check("e_imm", e_imm, stg[0].imm);
        check("bubble", 32'(bubble), 32'(stg[0].bub));
        check("m_rw", 32'(m_rw), 32'(stg[1].rw));
        check("m_reg_write", 32'(m_reg_write), 32'(stg[1].wr));
        check("m_memtoreg", 32'(m_memtoreg), 32'(stg[1].ld));
        check("w_rw", 32'(w_rw), 32'(stg[2].rw));
        check("w_reg_write", 32'(w_reg_write), 32'(stg[2].wr));
        check("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    endtask

    // Advance one clock, update the model from the inputs held across the edge, optionally check.
    task automatic step(input bit chk);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) stg[i] = '0;
            stg[0].bub = 1'b1;
            model_cnt  = 0;
        end else begin
            stg[2] = stg[1];
            stg[1] = stg[0];
            stg[0] = (flush || !wrn) ? empty_slot() : decode_slot();
            if (!wrn && !flush && model_cnt < 65535) model_cnt++;
        end
        #1;
        if (chk) check_all();
    endtask

    task automatic rand_d();
        d_rs        = 5'($urandom);
        d_rt        = 5'($urandom);
        d_rw        = 5'($urandom);
        d_reg_write = 1'($urandom);
        d_memtoreg  = 1'($urandom);
        d_wmem      = 1'($urandom);
        d_aluc      = 4'($urandom);
        d_qa        = $urandom;
        d_qb        = $urandom;
        d_imm       = $urandom;
    endtask

    task automatic set_instr(input logic [4:0] rw, input logic wr, input logic ld);
        rand_d();
        d_rw        = rw;
        d_reg_write = wr;
        d_memtoreg  = ld;
        d_wmem      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) stg[i] = empty_slot();
        rst = 1'b1; wrn = 1'b1; flush = 1'b0;
        rand_d();
        // Reset with random ID-stage contents.
        step(1'b1);
        rand_d();
        step(1'b1);
        check("reset_bubble", 32'(bubble), 32'd1);
        rst = 1'b0;

        // lw $8 followed by three adds.
        set_instr(5'd8, 1'b1, 1'b1);  step(1'b1);
        set_instr(5'd9, 1'b1, 1'b0);  step(1'b1);
        check("flow_m_memtoreg", 32'(m_memtoreg), 32'd1);
        set_instr(5'd10, 1'b1, 1'b0); step(1'b1);
        check("flow_w_rw", 32'(w_rw), 32'd8);
        check("flow_m_rw", 32'(m_rw), 32'd9);
        check("flow_e_rw", 32'(e_rw), 32'd10);
        set_instr(5'd11, 1'b1, 1'b0); step(1'b1);

        // Load-use stall: lw $8 in EXE, dependent instruction held in ID.
        set_instr(5'd8, 1'b1, 1'b1);  step(1'b1);
        set_instr(5'd13, 1'b1, 1'b0);
        wrn = 1'b0;                   step(1'b1);
        check("stall_e_rw", 32'(e_rw), 32'd0);
        check("stall_bubble", 32'(bubble), 32'd1);
        check("stall_m_rw", 32'(m_rw), 32'd8);
        check("stall_m_memtoreg", 32'(m_memtoreg), 32'd1);
        wrn = 1'b1;                   step(1'b1);
        check("replay_e_rw", 32'(e_rw), 32'd13);

        // Destination sanitising.
        set_instr(5'd12, 1'b0, 1'b1); step(1'b1);
        check("sanit_dead_rw", 32'(e_rw), 32'd0);
        set_instr(5'd0, 1'b1, 1'b1);  step(1'b1);
        check("sanit_zero_wr", 32'(e_reg_write), 32'd0);

        // Flush beats stall; not counted as a stall.
        set_instr(5'd14, 1'b1, 1'b0);
        flush = 1'b1; wrn = 1'b0;     step(1'b1);
        check("flush_bubble", 32'(bubble), 32'd1);
        flush = 1'b0; wrn = 1'b1;

        // Random traffic including stalls, flushes and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            rand_d();
            wrn   = ($urandom_range(3) != 0);
            flush = ($urandom_range(7) == 0);
            rst   = ($urandom_range(49) == 0);
            step(1'b1);
        end
        rst = 1'b0; wrn = 1'b1; flush = 1'b0;

`ifdef STALL_STATS_EN
        // Counter saturation, then reset clears it.
        wrn = 1'b0;
        for (int n = 0; n < 70000; n++) step(1'b0);
        step(1'b1);
        check("sat_cnt", 32'(stall_cnt), 32'h0000FFFF);
        step(1'b1);
        check("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        rst = 1'b1; step(1'b1);
        check("sat_reset", 32'(stall_cnt), 32'd0);
        rst = 1'b0; wrn = 1'b1;
`endif
        step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
